fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 65 ++++++
 rtl/fetch_ctrl.sv | 87 ++++++++
 tb/tb_fetch_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
// Holds the FSM state encoding, queue entry layout and default parameters.
package fetch_pkg;

    typedef enum logic {
        ST_FETCH = 1'b0,
        ST_HALT  = 1'b1
    } state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    localparam logic [31:0] DEFAULT_RESET_PC    = 32'h0000_0000;
    localparam logic [6:0]  DEFAULT_HALT_OPCODE = 7'b1111111;
    localparam logic [1:0]  QUEUE_DEPTH         = 2'd2;
    localparam logic [31:0] PC_ALIGN_MASK       = 32'hFFFF_FFFC;
    localparam logic [31:0] PC_STEP             = 32'd4;

    // True when the opcode field of a fetched word is the halt opcode.
    function automatic logic is_halt(input logic [6:0] opcode_field,
                                     input logic [6:0] halt_opcode);
        return (opcode_field == halt_opcode);
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// Two-entry {pc, instr} queue between fetch and decode.
// Head is always entry 0; flush wins over push and pop.
module fetch_queue
    import fetch_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  logic       pop,
    input  logic       flush,
    input  entry_t     push_entry,
    output logic [1:0] count,
    output entry_t     head
);

    entry_t     entry0_r;
    entry_t     entry1_r;
    logic [1:0] count_r;
    logic       pop_ok_s;
    logic       push_ok_s;

    assign pop_ok_s  = pop && (count_r != 2'd0);
    assign push_ok_s = push && ((count_r < QUEUE_DEPTH) || pop_ok_s);

    // Queue storage and occupancy; simultaneous push and pop keep count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_r <= '0;
            entry1_r <= '0;
            count_r  <= 2'd0;
        end else if (flush) begin
            count_r <= 2'd0;
        end else begin
            case ({push_ok_s, pop_ok_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        entry0_r <= push_entry;
                    end else begin
                        entry1_r <= push_entry;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    entry0_r <= entry1_r;
                    count_r  <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        entry0_r <= push_entry;
                    end else begin
                        entry0_r <= entry1_r;
                        entry1_r <= push_entry;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign count = count_r;
    assign head  = entry0_r;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: sequential fetch into a two-entry queue,
// redirect handling and halt-on-opcode with drain to decode.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter logic [6:0]  HALT_OPCODE = DEFAULT_HALT_OPCODE
)
(
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        halted
);

    state_t      state_r;
    logic [31:0] fetch_pc_r;
    logic [1:0]  count_s;
    entry_t      head_s;
    entry_t      push_entry_s;
    logic        pop_s;
    logic        can_fetch_s;
    logic        halt_hit_s;
    logic        push_s;

    // Redirect overrides everything: no pop, no push, no halt detection.
    assign pop_s        = (count_s != 2'd0) && id_ready && !redirect_valid;
    assign can_fetch_s  = (state_r == ST_FETCH) && !redirect_valid &&
                          ((count_s < QUEUE_DEPTH) || pop_s);
    assign halt_hit_s   = can_fetch_s && is_halt(imem_instr[6:0], HALT_OPCODE);
    assign push_s       = can_fetch_s && !halt_hit_s;
    assign push_entry_s = '{pc: fetch_pc_r, instr: imem_instr};

    fetch_queue u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push_s),
        .pop        (pop_s),
        .flush      (redirect_valid),
        .push_entry (push_entry_s),
        .count      (count_s),
        .head       (head_s)
    );

    // Fetch FSM and fetch PC; the halting word is left unfetched so fetch_pc holds on it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_FETCH;
            fetch_pc_r <= RESET_PC & PC_ALIGN_MASK;
        end else if (redirect_valid) begin
            state_r    <= ST_FETCH;
            fetch_pc_r <= redirect_pc & PC_ALIGN_MASK;
        end else begin
            case (state_r)
                ST_FETCH: begin
                    if (halt_hit_s) begin
                        state_r <= ST_HALT;
                    end else if (push_s) begin
                        fetch_pc_r <= fetch_pc_r + PC_STEP;
                    end else begin
                        fetch_pc_r <= fetch_pc_r;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r <= ST_FETCH;
                end
            endcase
        end
    end

    assign imem_addr = fetch_pc_r;
    assign if_valid  = (count_s != 2'd0);
    assign if_instr  = head_s.instr;
    assign if_pc     = head_s.pc;
    assign halted    = (state_r == ST_HALT) && (count_s == 2'd0);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table, hand-written halt/redirect/reset
// sequences, and randomized traffic against a queue-based reference model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        halted;

    logic [31:0] mem [0:63];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // Low 256 bytes come from mem; everything above is a non-halting addi-like word.
    assign imem_instr = (imem_addr[31:8] == 24'd0) ? mem[imem_addr[7:2]]
                                                   : {imem_addr[31:7], 7'h13};

    fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_ready       (id_ready),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .halted         (halted)
    );

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a[31:8] == 24'd0) return mem[a[7:2]];
        return {a[31:7], 7'h13};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_pc;
    bit          m_halt;

    task automatic model_reset();
        mq.delete();
        m_pc   = 32'h0;
        m_halt = 1'b0;
    endtask

    task automatic model_step(input logic red, input logic [31:0] rpc, input logic rdy);
        int          sz;
        bit          popped;
        logic [31:0] w;
        if (red) begin
            mq.delete();
            m_pc   = {rpc[31:2], 2'b00};
            m_halt = 1'b0;
        end else begin
            sz     = mq.size();
            popped = (sz > 0) && rdy;
            if (popped) void'(mq.pop_front());
            if (!m_halt && (sz < 2 || popped)) begin
                w = word_at(m_pc);
                if (w[6:0] == 7'h7F) begin
                    m_halt = 1'b1;
                end else begin
                    mq.push_back('{pc: m_pc, instr: w});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic model_check();
        check("rnd_valid", {31'd0, if_valid}, {31'd0, mq.size() != 0});
        check("rnd_halted", {31'd0, halted}, {31'd0, m_halt && mq.size() == 0});
        check("rnd_addr", imem_addr, m_pc);
        if (mq.size() != 0) begin
            check("rnd_pc", if_pc, mq[0].pc);
            check("rnd_instr", if_instr, mq[0].instr);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    // Called at a negedge: drive, take one rising edge, return at the next negedge.
    task automatic cycle(input logic red, input logic [31:0] rpc, input logic rdy);
        redirect_valid = red;
        redirect_pc    = rpc;
        id_ready       = rdy;
        @(posedge clk);
        model_step(red, rpc, rdy);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        repeat (2) @(negedge clk);
        model_reset();
        rst_n = 1'b1;
    endtask

    task automatic fill_addi();
        for (int i = 0; i < 64; i++) mem[i] = {20'(i * 3 + 1), 5'd1, 7'h13};
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        red;
        logic [31:0] rpc;
        logic        rdy;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_halted;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t tbl[15];

    initial begin
        // Fetch, stall with full queue, resume, redirect to unaligned target, wrap.
        tbl[0]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 32'h4};
        tbl[1]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 32'h8};
        tbl[2]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 32'h8};
        tbl[3]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 32'h8};
        tbl[4]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 32'h8};
        tbl[5]  = '{1'b0, 32'h0,         1'b0, 1'b1, 32'h0,         1'b0, 32'h8};
        tbl[6]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h4,         1'b0, 32'hC};
        tbl[7]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h8,         1'b0, 32'h10};
        tbl[8]  = '{1'b0, 32'h0,         1'b1, 1'b1, 32'hC,         1'b0, 32'h14};
        tbl[9]  = '{1'b1, 32'h3E,        1'b1, 1'b0, 32'h0,         1'b0, 32'h3C};
        tbl[10] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h3C,        1'b0, 32'h40};
        tbl[11] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h40,        1'b0, 32'h44};
        tbl[12] = '{1'b1, 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0,         1'b0, 32'hFFFF_FFFC};
        tbl[13] = '{1'b0, 32'h0,         1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0};
        tbl[14] = '{1'b0, 32'h0,         1'b1, 1'b1, 32'h0,         1'b0, 32'h4};

        fill_addi();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b0;
        #1;
        check("reset_valid", {31'd0, if_valid}, 32'd0);
        check("reset_instr", if_instr, 32'd0);
        check("reset_pc", if_pc, 32'd0);
        check("reset_halted", {31'd0, halted}, 32'd0);
        check("reset_addr", imem_addr, 32'h0);

        do_reset();
        for (int i = 0; i < 15; i++) begin
            cycle(tbl[i].red, tbl[i].rpc, tbl[i].rdy);
            check($sformatf("tbl%0d_valid", i), {31'd0, if_valid}, {31'd0, tbl[i].exp_valid});
            check($sformatf("tbl%0d_halted", i), {31'd0, halted}, {31'd0, tbl[i].exp_halted});
            check($sformatf("tbl%0d_addr", i), imem_addr, tbl[i].exp_addr);
            if (tbl[i].exp_valid) begin
                check($sformatf("tbl%0d_pc", i), if_pc, tbl[i].exp_pc);
                check($sformatf("tbl%0d_instr", i), if_instr, word_at(tbl[i].exp_pc));
            end
        end

        // Halt at word 5: words 0..4 stream out, then halted with fetch parked at 20.
        fill_addi();
        mem[5] = 32'h0190_257F;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            cycle(1'b0, 32'h0, 1'b1);
            check($sformatf("halt_seq%0d_valid", k), {31'd0, if_valid}, 32'd1);
            check($sformatf("halt_seq%0d_pc", k), if_pc, 32'(k * 4));
            check($sformatf("halt_seq%0d_halted", k), {31'd0, halted}, 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            cycle(1'b0, 32'h0, 1'b1);
            check($sformatf("halt_hold%0d_valid", k), {31'd0, if_valid}, 32'd0);
            check($sformatf("halt_hold%0d_halted", k), {31'd0, halted}, 32'd1);
            check($sformatf("halt_hold%0d_addr", k), imem_addr, 32'd20);
        end

        // Redirect out of halt resumes at the target.
        cycle(1'b1, 32'h0, 1'b1);
        check("resume_halted", {31'd0, halted}, 32'd0);
        check("resume_valid", {31'd0, if_valid}, 32'd0);
        check("resume_addr", imem_addr, 32'h0);
        cycle(1'b0, 32'h0, 1'b1);
        check("resume_pc0", if_pc, 32'h0);
        check("resume_valid0", {31'd0, if_valid}, 32'd1);
        cycle(1'b0, 32'h0, 1'b0);
        check("resume_pc_hold", if_pc, 32'h0);

        // Asynchronous reset mid-stream with a queued entry.
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'd0, if_valid}, 32'd0);
        check("midrst_pc", if_pc, 32'd0);
        check("midrst_instr", if_instr, 32'd0);
        check("midrst_addr", imem_addr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        cycle(1'b0, 32'h0, 1'b1);
        check("restart_valid", {31'd0, if_valid}, 32'd1);
        check("restart_pc", if_pc, 32'h0);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 64; i++) begin
            logic [31:0] w;
            w = $urandom;
            if ($urandom_range(0, 7) == 0) w[6:0] = 7'h7F;
            else if (w[6:0] == 7'h7F) w[6:0] = 7'h13;
            mem[i] = w;
        end
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        red;
            logic [31:0] rpc;
            logic        rdy;
            model_check();
            if ($urandom_range(0, 399) == 0) begin
                rst_n = 1'b0;
                #1;
                check("rnd_rst_valid", {31'd0, if_valid}, 32'd0);
                check("rnd_rst_halted", {31'd0, halted}, 32'd0);
                check("rnd_rst_addr", imem_addr, 32'h0);
                @(negedge clk);
                rst_n = 1'b1;
                model_reset();
            end else begin
                red = ($urandom_range(0, 9) == 0);
                rpc = ($urandom_range(0, 3) == 0) ? 32'($urandom) : 32'($urandom_range(0, 255));
                rdy = ($urandom_range(0, 3) != 0);
                cycle(red, rpc, rdy);
            end
        end
        model_check();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
